// File: rtl/aes_top.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Optional macro AES_OUTPUT_CLEAR_EN zeroes ciphertext from the accepting edge until the done edge.
module aes_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] state_reg, state_next;
    logic [127:0] rkey_reg, rkey_next;
    logic [127:0] ct_reg, ct_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic         done_reg, done_next;

    localparam logic [0:255][7:0] sbox_rom = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_lu(input logic [7:0] a);
        return sbox_rom[a];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte i of the state is bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    logic [7:0]   sub_b [16];
    logic [7:0]   shf_b [16];
    logic [7:0]   mix_b [16];
    logic [7:0]   sw_b  [4];
    logic [127:0] shf_w, mix_w, key_new;
    logic [31:0]  w3_rot, temp_w;

    assign w3_rot = {rkey_reg[23:0], rkey_reg[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            assign sub_b[gi] = sbox_lu(state_reg[127-8*gi -: 8]);
            assign shf_b[gi] = sub_b[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
        end
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign mix_b[4*gi+0] = xtime(shf_b[4*gi]) ^ xtime(shf_b[4*gi+1]) ^ shf_b[4*gi+1] ^ shf_b[4*gi+2] ^ shf_b[4*gi+3];
            assign mix_b[4*gi+1] = shf_b[4*gi] ^ xtime(shf_b[4*gi+1]) ^ xtime(shf_b[4*gi+2]) ^ shf_b[4*gi+2] ^ shf_b[4*gi+3];
            assign mix_b[4*gi+2] = shf_b[4*gi] ^ shf_b[4*gi+1] ^ xtime(shf_b[4*gi+2]) ^ xtime(shf_b[4*gi+3]) ^ shf_b[4*gi+3];
            assign mix_b[4*gi+3] = xtime(shf_b[4*gi]) ^ shf_b[4*gi] ^ shf_b[4*gi+1] ^ shf_b[4*gi+2] ^ xtime(shf_b[4*gi+3]);
            assign sw_b[gi]      = sbox_lu(w3_rot[31-8*gi -: 8]);
        end
    endgenerate

    assign temp_w = {sw_b[0], sw_b[1], sw_b[2], sw_b[3]} ^ {rcon(cnt_reg), 24'h0};
    assign key_new[127:96] = rkey_reg[127:96] ^ temp_w;
    assign key_new[95:64]  = rkey_reg[95:64]  ^ key_new[127:96];
    assign key_new[63:32]  = rkey_reg[63:32]  ^ key_new[95:64];
    assign key_new[31:0]   = rkey_reg[31:0]   ^ key_new[63:32];

    always_comb begin
        shf_w = '0;
        mix_w = '0;
        for (int i = 0; i < 16; i++) begin
            shf_w[127-8*i -: 8] = shf_b[i];
            mix_w[127-8*i -: 8] = mix_b[i];
        end
    end

    always_comb begin
        fsm_next   = fsm_reg;
        state_next = state_reg;
        rkey_next  = rkey_reg;
        cnt_next   = cnt_reg;
        ct_next    = ct_reg;
        done_next  = 1'b0;
        case (fsm_reg)
            IDLE: begin
                if (start) begin
                    fsm_next   = RUN;
                    state_next = plaintext ^ key;
                    rkey_next  = key;
                    cnt_next   = 4'd1;
`ifdef AES_OUTPUT_CLEAR_EN
                    ct_next    = '0;
`else
                    ct_next    = ct_reg;
`endif
                end
            end
            RUN: begin
                rkey_next = key_new;
                cnt_next  = cnt_reg + 4'd1;
                if (cnt_reg == 4'd10) begin
                    // Final round skips MixColumns and publishes the result.
                    state_next = shf_w ^ key_new;
                    ct_next    = shf_w ^ key_new;
                    done_next  = 1'b1;
                    cnt_next   = 4'd0;
                    fsm_next   = IDLE;
                end else begin
                    state_next = mix_w ^ key_new;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            rkey_reg  <= '0;
            cnt_reg   <= '0;
            ct_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            fsm_reg   <= fsm_next;
            state_reg <= state_next;
            rkey_reg  <= rkey_next;
            cnt_reg   <= cnt_next;
            ct_reg    <= ct_next;
            done_reg  <= done_next;
        end
    end

    assign ciphertext = ct_reg;
    assign busy       = (fsm_reg == RUN);
    assign done       = done_reg;
endmodule

// File: tb/tb_aes_top.sv
// Bench for aes_top: directed FIPS-197 vectors plus random blocks checked against
// a GF(2^8)-arithmetic AES-128 model; covers held start, reset mid-run and output hold/clear.
module tb_aes_top;
    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;
    logic [127:0] prev_ct;
    logic [7:0]   sb_tbl [256];

    aes_top dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .ciphertext (ciphertext),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, v[7:0]);
            b = inv;
            sb_tbl[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  acc;
        logic [7:0]  coef [4];
        logic [127:0] res;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb_tbl[tmp[23:16]], sb_tbl[tmp[15:8]], sb_tbl[tmp[7:0]], sb_tbl[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = sb_tbl[s[4*((c+row)%4)+row]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) begin
                    if (r < 10) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-row+4)%4], t[4*c+j]);
                    end else begin
                        acc = t[4*c+row];
                    end
                    s[4*c+row] = acc ^ w[4*r+c][31-8*row -: 8];
                end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] busy_ct();
`ifdef AES_OUTPUT_CLEAR_EN
        return '0;
`else
        return prev_ct;
`endif
    endfunction

    // Entered at #1 after a rising edge with the DUT idle (or in its done cycle).
    task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp,
                             input bit hold_start, input logic [127:0] pt2, input logic [127:0] k2);
        plaintext = pt;
        key       = k;
        start     = 1'b1;
        @(posedge clk); #1;
        chk("accept_busy", {127'b0, busy}, 128'd1);
        chk("accept_done", {127'b0, done}, 128'd0);
        chk("accept_ct", ciphertext, busy_ct());
        if (!hold_start) start = 1'b0;
        plaintext = pt2;
        key       = k2;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i < 10) begin
                chk("run_busy", {127'b0, busy}, 128'd1);
                chk("run_done", {127'b0, done}, 128'd0);
                chk("run_ct", ciphertext, busy_ct());
            end else begin
                chk("done_pulse", {127'b0, done}, 128'd1);
                chk("done_busy", {127'b0, busy}, 128'd0);
                chk("done_ct", ciphertext, exp);
            end
        end
        prev_ct = exp;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("post_done", {127'b0, done}, 128'd0);
        chk("hold_ct", ciphertext, prev_ct);
    endtask

    initial begin
        logic [127:0] p, k, p2, k2;
        build_sbox();
        rst = 1'b1;
        start = 1'b1;
        plaintext = rnd128();
        key = rnd128();
        prev_ct = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ct", ciphertext, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_done", {127'b0, done}, 128'd0);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", {127'b0, busy}, 128'd0);

        run_block(128'h0, 128'h0, 128'h66E94BD4EF8A2C3B884CFA59CA342B2E, 1'b0, rnd128(), rnd128());
        idle_cycle();
        run_block(128'h6BC1BEE22E409F96E93D7E117393172A, 128'h2B7E151628AED2A6ABF7158809CF4F3C,
                  128'h3AD77BB40D7A3660A89ECAF32466EF97, 1'b0, rnd128(), rnd128());
        idle_cycle();
        run_block(128'hAE2D8A571E03AC9C9EB76FAC45AF8E51, 128'h2B7E151628AED2A6ABF7158809CF4F3C,
                  128'hF5D3D58503B9699DE785895A96FDBAAF, 1'b0, rnd128(), rnd128());
        idle_cycle();
        run_block(128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F,
                  128'h69C4E0D86A7B0430D8CDB78070B4C55A, 1'b0, rnd128(), rnd128());
        idle_cycle();

        for (int n = 0; n < 4; n++) begin
            p = rnd128();
            k = rnd128();
            run_block(p, k, aes_ref(p, k), 1'b0, rnd128(), rnd128());
            idle_cycle();
        end

        // start held high, inputs changed mid-run; second block accepted in the done cycle
        p = rnd128(); k = rnd128(); p2 = rnd128(); k2 = rnd128();
        run_block(p, k, aes_ref(p, k), 1'b1, p2, k2);
        run_block(p2, k2, aes_ref(p2, k2), 1'b0, rnd128(), rnd128());
        idle_cycle();

        // asynchronous reset while round 5 is in flight
        plaintext = rnd128();
        key = rnd128();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_abort_busy", {127'b0, busy}, 128'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {127'b0, busy}, 128'd0);
        chk("abort_done", {127'b0, done}, 128'd0);
        chk("abort_ct", ciphertext, 128'd0);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_busy", {127'b0, busy}, 128'd0);
        rst = 1'b0;
        start = 1'b0;
        prev_ct = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {127'b0, done}, 128'd0);
        end
        chk("abort_ct_after", ciphertext, 128'd0);
        p = rnd128();
        k = rnd128();
        run_block(p, k, aes_ref(p, k), 1'b0, rnd128(), rnd128());
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
